game_flow_controller: RTL
=========================

// Module: game_flow_controller
// PURPOSE
//  Parametrised level sequencer for the mining game; next generation of the single-path level controller.
//  Adds the following over the single-path version:
//   - lives with retry of a failed level
//   - pause
//   - selectable goal-progression mode
//   - saturating goal/time arithmetic
//   - explicit win/lose states
//  Sits between the keyboard/timer/score units and all per-level objects.
//  Broadcasts level number, goal and timer preset, and a one-cycle start_level pulse.
// PARAMETERS
//  MAX_LEVEL   5    last level index (1-based); must fit in LEVEL_W
//  LEVEL_W     3    width of level_num
//  SCORE_W     14   width of score and goal
//  TIME_W      8    width of timer_time
//  INIT_GOAL   160  goal of level 1
//  GOAL_STEP   40   per-level goal increment (GOAL_MODE=0)
//  GOAL_MODE   0    0: goal=INIT_GOAL+GOAL_STEP*(n-1); 1: goal=INIT_GOAL<<(n-1)
//  INIT_TIME   40   timer preset of level 1
//  TIME_DT     5    timer increment per level
//  MAX_LIVES   3    lives at game start; width of lives = $clog2(MAX_LIVES+1)
// PORTS
//  clk          in   1        system clock
//  resetN       in   1        asynchronous, active-low reset
//  score        in   SCORE_W  accumulated score of current level
//  next_level   in   1        one-cycle pulse from player: start / continue
//  skip_level   in   1        one-cycle pulse: abandon level, advance without scoring check
//  level_ended  in   1        one-cycle pulse from timer/objects: level over
//  pause_req    in   1        one-cycle pulse: toggle pause
//  start_level  out  1        one-cycle pulse, first cycle of PLAY
//  level_num    out  LEVEL_W  current level, 1..MAX_LEVEL; 0 in IDLE
//  goal         out  SCORE_W  score required to pass current level
//  timer_time   out  TIME_W   timer preset for current level
//  lives        out  LW       remaining lives
//  paused       out  1        high while in PAUSE (timer/objects freeze)
//  game_won     out  1        high in WIN
//  game_over    out  1        high in LOSE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0.
//  All outputs are registered and change only on clk edges.
//  States: IDLE, READY, PLAY, PAUSE, LEVEL_END, INTERMISSION, WIN, LOSE.
//  IDLE:
//   - level_num/goal/timer_time/lives held 0.
//   - next_level -> READY with level_num=1, lives=MAX_LIVES.
//  Entry to READY:
//   - level_num, goal and timer_time are loaded in the same edge as the state change.
//   - Values are stable through READY, PLAY, PAUSE, LEVEL_END and INTERMISSION.
//  Goal arithmetic:
//   - goal is computed at width SCORE_W+LEVEL_W+1.
//   - Saturates to 2^SCORE_W-1 on overflow.
//   - GOAL_MODE=1 shift also saturates.
//  Timer arithmetic:
//   - timer_time = INIT_TIME + TIME_DT*(n-1).
//   - Saturates to 2^TIME_W-1.
//  READY: next_level -> PLAY. start_level=1 for exactly the first PLAY cycle.
//  PLAY, priority level_ended > skip_level > pause_req (lower-priority inputs in the same cycle are dropped):
//   - level_ended -> LEVEL_END.
//   - skip_level -> READY with level_num+1; lives unchanged. At level_num==MAX_LEVEL -> WIN.
//   - pause_req -> PAUSE.
//  PAUSE:
//   - paused=1.
//   - Only pause_req is honoured (-> PLAY, no start_level pulse).
//   - level_ended, skip_level and next_level are ignored.
//  LEVEL_END (exactly 1 cycle); pass = (score >= goal), sampled in this cycle:
//   - pass & level_num<MAX_LEVEL -> INTERMISSION (advance).
//   - pass & level_num==MAX_LEVEL -> WIN.
//   - !pass & lives>1 -> lives-1, INTERMISSION (retry same level).
//   - !pass & lives==1 -> lives=0, LOSE.
//  INTERMISSION: next_level -> READY with level_num+1 (advance) or the same level_num (retry).
//  WIN / LOSE:
//   - game_won / game_over held high.
//   - next_level -> IDLE, which clears all outputs.
//  Inputs outside the states listed are ignored. A held-high next_level advances at most one state per cycle.
// TESTING
//  1. Reset; pulse next_level twice -> level_num=1, goal=160, timer_time=40, start_level high exactly 1 cycle.
//  2. Level 1: score=160, level_ended -> INTERMISSION; next_level x2 -> level_num=2, goal=200, timer_time=45.
//  3. Level 1: score=159, level_ended -> lives 3->2, retry level 1 keeps goal=160; repeat fail x2 -> game_over=1, lives=0.
//  4. Level 5: pass -> game_won=1; next_level -> IDLE with all outputs 0.
//  5. PLAY: pause_req -> paused=1; level_ended while paused ignored; pause_req -> PLAY, no start_level. Same cycle level_ended+skip_level -> LEVEL_END.
//  6. GOAL_MODE=1, INIT_GOAL=5000, SCORE_W=14: level 3 goal saturates to 16383. resetN low mid-PLAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/game_flow_if.sv
// Handshake bundle between the level sequencer and the keyboard/timer/score/object units.
// The master side drives requests and score; the slave side (the sequencer) drives level info.
interface game_flow_if #(
   parameter int LEVEL_W = 3,
   parameter int SCORE_W = 14,
   parameter int TIME_W  = 8,
   parameter int LIVES_W = 2
);
   logic [SCORE_W-1:0] score;
   logic               next_level;
   logic               skip_level;
   logic               level_ended;
   logic               pause_req;

   logic               start_level;
   logic [LEVEL_W-1:0] level_num;
   logic [SCORE_W-1:0] goal;
   logic [TIME_W-1:0]  timer_time;
   logic [LIVES_W-1:0] lives;
   logic               paused;
   logic               game_won;
   logic               game_over;

   modport master (
      output score, next_level, skip_level, level_ended, pause_req,
      input  start_level, level_num, goal, timer_time, lives, paused, game_won, game_over
   );

   modport slave (
      input  score, next_level, skip_level, level_ended, pause_req,
      output start_level, level_num, goal, timer_time, lives, paused, game_won, game_over
   );
endinterface

// File: rtl/game_flow_controller.sv
// Level sequencer for the mining game: lives with retry, pause, win/lose, and
// saturating per-level goal and timer presets loaded on entry to READY.
module game_flow_controller #(
   parameter int MAX_LEVEL = 5,
   parameter int LEVEL_W   = 3,
   parameter int SCORE_W   = 14,
   parameter int TIME_W    = 8,
   parameter int INIT_GOAL = 160,
   parameter int GOAL_STEP = 40,
   parameter int GOAL_MODE = 0,
   parameter int INIT_TIME = 40,
   parameter int TIME_DT   = 5,
   parameter int MAX_LIVES = 3
) (
   input  logic       clk,
   input  logic       resetN,
   game_flow_if.slave bus
);
   localparam int LW = $clog2(MAX_LIVES + 1);
   localparam int GW = SCORE_W + LEVEL_W + 1;
   localparam int TW = TIME_W + LEVEL_W + 1;
   localparam logic [GW-1:0] GOAL_SAT = GW'({SCORE_W{1'b1}});
   localparam logic [TW-1:0] TIME_SAT = TW'({TIME_W{1'b1}});
   localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(MAX_LEVEL);

   typedef enum logic [2:0] {
      S_IDLE, S_READY, S_PLAY, S_PAUSE, S_LEVEL_END, S_INTERMISSION, S_WIN, S_LOSE
   } state_t;

   // Clamp after every step so the running value never exceeds the wide accumulator.
   function automatic logic [SCORE_W-1:0] level_goal(input logic [LEVEL_W-1:0] n);
      logic [GW-1:0] g;
      g = GW'(INIT_GOAL);
      if (g > GOAL_SAT) g = GOAL_SAT;
      for (int i = 1; i < (1 << LEVEL_W); i++) begin
         if (LEVEL_W'(i) < n) begin
            g = (GOAL_MODE == 1) ? (g << 1) : (g + GW'(GOAL_STEP));
            if (g > GOAL_SAT) g = GOAL_SAT;
         end
      end
      return g[SCORE_W-1:0];
   endfunction

   function automatic logic [TIME_W-1:0] level_time(input logic [LEVEL_W-1:0] n);
      logic [TW-1:0] t;
      t = TW'(INIT_TIME);
      if (t > TIME_SAT) t = TIME_SAT;
      for (int i = 1; i < (1 << LEVEL_W); i++) begin
         if (LEVEL_W'(i) < n) begin
            t = t + TW'(TIME_DT);
            if (t > TIME_SAT) t = TIME_SAT;
         end
      end
      return t[TIME_W-1:0];
   endfunction

   state_t             state_q;
   logic               advance_q;
   logic               start_q, paused_q, won_q, over_q;
   logic [LEVEL_W-1:0] level_q;
   logic [SCORE_W-1:0] goal_q;
   logic [TIME_W-1:0]  time_q;
   logic [LW-1:0]      lives_q;

   logic [LEVEL_W-1:0] load_level;
   logic [SCORE_W-1:0] load_goal;
   logic [TIME_W-1:0]  load_time;

   always_comb begin
      // NOTE: default first so every path assigns load_level and no latch is inferred.
      load_level = level_q + LEVEL_W'(1);
      if (state_q == S_IDLE)
         load_level = LEVEL_W'(1);
      else if (state_q == S_INTERMISSION && !advance_q)
         load_level = level_q;
   end

   assign load_goal = level_goal(load_level);
   assign load_time = level_time(load_level);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= S_IDLE;
         advance_q <= 1'b0;
         start_q   <= 1'b0;
         paused_q  <= 1'b0;
         won_q     <= 1'b0;
         over_q    <= 1'b0;
         level_q   <= '0;
         goal_q    <= '0;
         time_q    <= '0;
         lives_q   <= '0;
      end else begin
         // NOTE: non-blocking throughout so every register updates from pre-edge values.
         start_q <= 1'b0;
         case (state_q)
            S_IDLE: if (bus.next_level) begin
               state_q <= S_READY;
               level_q <= load_level;
               goal_q  <= load_goal;
               time_q  <= load_time;
               lives_q <= LW'(MAX_LIVES);
            end
            S_READY: if (bus.next_level) begin
               state_q <= S_PLAY;
               start_q <= 1'b1;
            end
            S_PLAY: begin
               if (bus.level_ended) begin
                  state_q <= S_LEVEL_END;
               end else if (bus.skip_level) begin
                  if (level_q == LAST_LEVEL) begin
                     state_q <= S_WIN;
                     won_q   <= 1'b1;
                  end else begin
                     state_q <= S_READY;
                     level_q <= load_level;
                     goal_q  <= load_goal;
                     time_q  <= load_time;
                  end
               end else if (bus.pause_req) begin
                  state_q  <= S_PAUSE;
                  paused_q <= 1'b1;
               end
            end
            S_PAUSE: if (bus.pause_req) begin
               state_q  <= S_PLAY;
               paused_q <= 1'b0;
            end
            S_LEVEL_END: begin
               if (bus.score >= goal_q) begin
                  advance_q <= 1'b1;
                  if (level_q == LAST_LEVEL) begin
                     state_q <= S_WIN;
                     won_q   <= 1'b1;
                  end else begin
                     state_q <= S_INTERMISSION;
                  end
               end else begin
                  advance_q <= 1'b0;
                  if (lives_q > LW'(1)) begin
                     lives_q <= lives_q - LW'(1);
                     state_q <= S_INTERMISSION;
                  end else begin
                     lives_q <= '0;
                     over_q  <= 1'b1;
                     state_q <= S_LOSE;
                  end
               end
            end
            S_INTERMISSION: if (bus.next_level) begin
               state_q <= S_READY;
               level_q <= load_level;
               goal_q  <= load_goal;
               time_q  <= load_time;
            end
            S_WIN, S_LOSE: if (bus.next_level) begin
               state_q <= S_IDLE;
               won_q   <= 1'b0;
               over_q  <= 1'b0;
               level_q <= '0;
               goal_q  <= '0;
               time_q  <= '0;
               lives_q <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.start_level = start_q;
   assign bus.level_num   = level_q;
   assign bus.goal        = goal_q;
   assign bus.timer_time  = time_q;
   assign bus.lives       = lives_q;
   assign bus.paused      = paused_q;
   assign bus.game_won    = won_q;
   assign bus.game_over   = over_q;
endmodule
